inst_rom_loader: RTL and testbench

//  Instruction store sitting directly upstream of Naive_CPU: drives its rom_data_i from rom_addr_o/rom_ce_o.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/inst_rom_loader_mem.sv | 25 ++
 rtl/inst_rom_loader.sv | 155 +++++++++++++++
 tb/tb_inst_rom_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction ROM loader.
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int LD_BYTE_W   = 8;
  // Widths of `InstBus and `InstAddrBus on the CPU side.
  localparam int INST_W      = 16;
  localparam int INST_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHK     = 3'd5,
    RUN     = 3'd6
  } ld_state_t;

  // States in which the host stream is being consumed.
  function automatic logic is_loading(input ld_state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHK);
  endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction storage: synchronous write, asynchronous read, never cleared.
module inst_mem
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Run-time loadable instruction ROM feeding the CPU fetch port; holds the CPU in reset until a load completes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every load.
module inst_rom_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_start_i,
  input  logic                   ld_valid_i,
  input  logic [LD_BYTE_W-1:0]   ld_byte_i,
  output logic                   ld_ready_o,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   cpu_rst_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [ADDR_W:0]        words_o,
  output ld_state_t              state_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  // Handshake: a byte transfers on every rising edge where ld_valid_i && ld_ready_o;
  // ld_ready_o depends only on the state register, never on ld_valid_i.
  ld_state_t             state;
  logic [LD_BYTE_W-1:0]  len_hi_q;
  logic [LD_BYTE_W-1:0]  data_hi_q;
  logic [ADDR_W:0]       len_q;
  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       ptr_nxt;
  logic [15:0]           len_field;
  logic                  accept;
  logic                  mem_we;
  logic [INST_W-1:0]     mem_rdata;
  logic                  rd_hit;

  assign ld_ready_o = is_loading(state);
  assign busy_o     = is_loading(state);
  assign state_o    = state;
  assign accept     = ld_valid_i && ld_ready_o;
  assign len_field  = {len_hi_q, ld_byte_i};
  assign ptr_nxt    = wr_ptr + (ADDR_W+1)'(1);
  // A restart in the same cycle wins, so the colliding byte must not reach memory.
  assign mem_we     = accept && !ld_start_i && (state == DATA_LO);

`ifdef LOADER_CHECKSUM_EN
  logic [LD_BYTE_W-1:0] xor_q;
  logic [LD_BYTE_W-1:0] xor_nxt;
  assign xor_nxt = xor_q ^ ld_byte_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_rst_o <= 1'b1;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      words_o   <= '0;
      wr_ptr    <= '0;
      len_q     <= '0;
      len_hi_q  <= '0;
      data_hi_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (ld_start_i) begin
        state     <= LEN_HI;
        cpu_rst_o <= 1'b1;
        err_o     <= 1'b0;
        wr_ptr    <= '0;
`ifdef LOADER_CHECKSUM_EN
        xor_q     <= '0;
`endif
      end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        xor_q <= xor_nxt;
`endif
        case (state)
          LEN_HI: begin
            len_hi_q <= ld_byte_i;
            state    <= LEN_LO;
          end
          LEN_LO: begin
            if (len_field == 16'h0000 || 32'(len_field) > DEPTH) begin
              err_o <= 1'b1;
              state <= IDLE;
            end else begin
              len_q <= len_field[ADDR_W:0];
              state <= DATA_HI;
            end
          end
          DATA_HI: begin
            data_hi_q <= ld_byte_i;
            state     <= DATA_LO;
          end
          DATA_LO: begin
            wr_ptr <= ptr_nxt;
            if (ptr_nxt == len_q) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state     <= RUN;
              words_o   <= len_q;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
`endif
            end else begin
              state <= DATA_HI;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHK: begin
            if (xor_nxt == '0) begin
              state     <= RUN;
              words_o   <= len_q;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
            end else begin
              err_o <= 1'b1;
              state <= IDLE;
            end
          end
`endif
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

  inst_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({data_hi_q, ld_byte_i}),
    .raddr (rom_addr_i[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // Words beyond the last successful load are stale, so they read as zero.
  assign rd_hit = rom_ce_i &&
                  (rom_addr_i[INST_ADDR_W-1:ADDR_W] == '0) &&
                  ({1'b0, rom_addr_i[ADDR_W-1:0]} < words_o);
  assign rom_data_o = rd_hit ? mem_rdata : '0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: table-driven reads plus hand-written load sequences.
module tb_inst_rom_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start_i;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_ready_o;
  logic        rom_ce_i;
  logic [15:0] rom_addr_i;
  logic [15:0] rom_data_o;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [8:0]  words_o;
  ld_state_t   state_o;

  inst_rom_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_ready_o (ld_ready_o),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .cpu_rst_o  (cpu_rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .words_o    (words_o),
    .state_o    (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  stream_q[$];
  logic [15:0] data_buf [256];
  logic [15:0] exp_mem  [256];
  int          exp_words = 0;
`ifdef LOADER_CHECKSUM_EN
  bit          corrupt_cs = 1'b0;
`endif

  typedef struct {
    logic        ce;
    logic [15:0] addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output logic done_after);
    int wait_cnt;
    ld_valid_i = 1'b0;
    repeat (gap) tick();
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    wait_cnt   = 0;
    while (!ld_ready_o && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    if (!ld_ready_o) begin
      check("ready_timeout", 32'(ld_ready_o), 32'd1);
      ld_valid_i = 1'b0;
      done_after = 1'b0;
    end else begin
      tick();
      ld_valid_i = 1'b0;
      done_after = done_o;
    end
  endtask

  task automatic build(input logic [15:0] n_field, input int nwords);
    stream_q.delete();
    stream_q.push_back(n_field[15:8]);
    stream_q.push_back(n_field[7:0]);
    for (int i = 0; i < nwords; i++) begin
      stream_q.push_back(data_buf[i][15:8]);
      stream_q.push_back(data_buf[i][7:0]);
      exp_mem[i] = data_buf[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (nwords > 0) begin
      logic [7:0] x;
      x = 8'h00;
      foreach (stream_q[k]) x ^= stream_q[k];
      stream_q.push_back(corrupt_cs ? ~x : x);
    end
`endif
  endtask

  task automatic send_stream(input string name, input int max_gap, input logic exp_done);
    logic d;
    logic last_d;
    int   early;
    int   n;
    n      = stream_q.size();
    early  = 0;
    last_d = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_byte(stream_q[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, d);
      if (i < n - 1 && d) early++;
      last_d = d;
    end
    check({name, "_done_early"}, 32'(early), 32'd0);
    check({name, "_done_last"}, 32'(last_d), 32'(exp_done));
  endtask

  // Scoreboard: expected read data queued when the address is driven, popped at mid-cycle.
  task automatic read_exp(input string name, input logic ce, input logic [15:0] addr, input logic [15:0] exp);
    exp_q.push_back(exp);
    rom_ce_i   = ce;
    rom_addr_i = addr;
    @(negedge clk);
    check(name, 32'(rom_data_o), 32'(exp_q.pop_front()));
    tick();
  endtask

  task automatic read_model(input string name, input logic ce, input logic [15:0] addr);
    logic [15:0] e;
    e = (ce && int'(addr) < exp_words) ? exp_mem[addr[7:0]] : 16'h0000;
    read_exp(name, ce, addr, e);
  endtask

  initial begin
    rst        = 1'b1;
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    ld_byte_i  = 8'h00;
    rom_ce_i   = 1'b0;
    rom_addr_i = 16'h0000;

    tbl[0] = '{1'b1, 16'h0000, 16'h3443};
    tbl[1] = '{1'b1, 16'h0001, 16'h0001};
    tbl[2] = '{1'b1, 16'h0002, 16'h0000};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000};
    tbl[4] = '{1'b0, 16'h0001, 16'h0000};

    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_state", 32'(state_o), 32'(IDLE));
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_ready", 32'(ld_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_words", 32'(words_o), 32'd0);
    read_model("rst_read0", 1'b1, 16'h0000);

    // Test 1: basic two-word load
    pulse_start();
    check("t1_state", 32'(state_o), 32'(LEN_HI));
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_ready", 32'(ld_ready_o), 32'd1);
    data_buf[0] = 16'h3443;
    data_buf[1] = 16'h0001;
    build(16'h0002, 2);
    send_stream("t1", 0, 1'b1);
    check("t1_cpu_rst_fall", 32'(cpu_rst_o), 32'd0);
    check("t1_words", 32'(words_o), 32'd2);
    check("t1_run", 32'(state_o), 32'(RUN));
    check("t1_idle_ready", 32'(ld_ready_o), 32'd0);
    exp_words = 2;
    tick();
    check("t1_done_pulse", 32'(done_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      read_exp($sformatf("t1_tbl%0d", i), tbl[i].ce, tbl[i].addr, tbl[i].exp);
    end

    // Test 2: illegal lengths
    pulse_start();
    build(16'h0000, 0);
    send_stream("t2_zero", 0, 1'b0);
    check("t2_zero_err", 32'(err_o), 32'd1);
    check("t2_zero_state", 32'(state_o), 32'(IDLE));
    check("t2_zero_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("t2_zero_words", 32'(words_o), 32'd2);
    pulse_start();
    check("t2_err_clear", 32'(err_o), 32'd0);
    build(16'h0101, 0);
    send_stream("t2_257", 0, 1'b0);
    check("t2_257_err", 32'(err_o), 32'd1);
    check("t2_257_cpu_rst", 32'(cpu_rst_o), 32'd1);
    read_model("t2_read1", 1'b1, 16'h0001);

    // Test 3: same load with random valid gaps
    pulse_start();
    build(16'h0002, 2);
    send_stream("t3", 5, 1'b1);
    check("t3_words", 32'(words_o), 32'd2);
    check("t3_err", 32'(err_o), 32'd0);
    for (int i = 0; i < 3; i++) read_model($sformatf("t3_read%0d", i), 1'b1, 16'(i));

    // Test 4: restart colliding with a byte, then reset mid-load
    pulse_start();
    data_buf[0] = 16'h1234;
    build(16'h0003, 1);
    for (int i = 0; i < 4; i++) begin
      logic d;
      send_byte(stream_q[i], 0, d);
    end
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'h56;
    ld_start_i = 1'b1;
    tick();
    ld_valid_i = 1'b0;
    ld_start_i = 1'b0;
    check("t4_restart_state", 32'(state_o), 32'(LEN_HI));
    check("t4_restart_err", 32'(err_o), 32'd0);
    data_buf[0] = 16'hABCD;
    build(16'h0001, 1);
    send_stream("t4", 0, 1'b1);
    exp_words = 1;
    check("t4_words", 32'(words_o), 32'd1);
    check("t4_err", 32'(err_o), 32'd0);
    read_exp("t4_read0", 1'b1, 16'h0000, 16'hABCD);
    read_exp("t4_read1", 1'b1, 16'h0001, 16'h0000);
    pulse_start();
    data_buf[0] = 16'h1122;
    build(16'h0002, 1);
    for (int i = 0; i < 4; i++) begin
      logic d;
      send_byte(stream_q[i], 0, d);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_words = 0;
    check("t4_rst_words", 32'(words_o), 32'd0);
    check("t4_rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("t4_rst_state", 32'(state_o), 32'(IDLE));
    check("t4_rst_busy", 32'(busy_o), 32'd0);
    read_model("t4_rst_read0", 1'b1, 16'h0000);
    read_model("t4_rst_read1", 1'b1, 16'h0001);

`ifdef LOADER_CHECKSUM_EN
    // Test 5: checksum accept and reject
    pulse_start();
    data_buf[0] = 16'h3443;
    corrupt_cs  = 1'b0;
    build(16'h0001, 1);
    send_stream("t5_good", 0, 1'b1);
    exp_words = 1;
    check("t5_good_words", 32'(words_o), 32'd1);
    pulse_start();
    data_buf[0] = 16'h1234;
    corrupt_cs  = 1'b1;
    build(16'h0001, 1);
    send_stream("t5_bad", 0, 1'b0);
    corrupt_cs  = 1'b0;
    check("t5_bad_err", 32'(err_o), 32'd1);
    check("t5_bad_words", 32'(words_o), 32'd1);
    check("t5_bad_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("t5_bad_state", 32'(state_o), 32'(IDLE));
    read_model("t5_read0", 1'b1, 16'h0000);
`endif

    // Test 6: full-depth load
    pulse_start();
    for (int i = 0; i < 256; i++) data_buf[i] = 16'(i) ^ 16'hA5A5;
    build(16'h0100, 256);
    send_stream("t6", 0, 1'b1);
    exp_words = 256;
    check("t6_words", 32'(words_o), 32'd256);
    check("t6_cpu_rst", 32'(cpu_rst_o), 32'd0);
    for (int i = 0; i < 256; i++) read_model($sformatf("t6_read%0d", i), 1'b1, 16'(i));
    read_exp("t6_read_0100", 1'b1, 16'h0100, 16'h0000);
    read_exp("t6_read_ffff", 1'b1, 16'hFFFF, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
